// File: rtl/logic16_serial_pkg.sv
// Shared definitions for the nibble-serial logic unit.
//   OP_*  : operation encodings carried on the Op port
//   ST_*  : 2-bit FSM state encodings used by the top level
package logic16_serial_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_ANDN = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/logic_slice.sv
// Combinational W-bit bitwise op unit: one slice of the serial logic unit.
// Ports:
//   a, b : slice operands
//   op   : operation select (AND / OR / XOR / ANDN = a & ~b)
//   y    : slice result
module logic_slice #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   op,
  output logic [W-1:0] y
);
  import logic16_serial_pkg::*;

  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_ANDN: y = a & ~b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic16_serial.sv
// Multi-cycle bitwise logic unit (AND/OR/XOR/ANDN), SLICE bits per cycle,
// LSB slice first, start/done handshake with busy for stall logic.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   start      : request, only accepted while busy==0
//   A, B, Op   : operands and operation, captured on the accepting edge
//   Out        : result, valid from done until the next accepted start
//   done       : one-cycle pulse when Out is final
//   busy       : high from the cycle after acceptance through the done cycle
//   Zero       : (only with LOGIC16_ZERO_FLAG_EN) result==0, valid with done,
//                held until the next accepted start
//
// State table:
//   ST_IDLE | waiting for start, Out holds last result
//   ST_RUN  | writing slice cnt of Out each cycle
//   ST_DONE | done pulse, then back to idle
module logic16_serial #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       Op,
  output logic [WIDTH-1:0] Out,
  output logic             done,
`ifdef LOGIC16_ZERO_FLAG_EN
  output logic             Zero,
`endif
  output logic             busy
);
  import logic16_serial_pkg::*;

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NSLICE - 1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [SLICE-1:0] slice_a, slice_b, slice_y;

  assign slice_a = a_q[cnt_q*SLICE +: SLICE];
  assign slice_b = b_q[cnt_q*SLICE +: SLICE];

  logic_slice #(.W(SLICE)) u_slice (
    .a  (slice_a),
    .b  (slice_b),
    .op (op_q),
    .y  (slice_y)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    out_d   = out_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          op_d    = Op;
          out_d   = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        out_d[cnt_q*SLICE +: SLICE] = slice_y;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_AND;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      out_q   <= out_d;
    end
  end

  assign Out  = out_q;
  assign done = (state_q == ST_DONE);
  assign busy = (state_q != ST_IDLE);

`ifdef LOGIC16_ZERO_FLAG_EN
  // nz_q remembers whether any earlier slice was non-zero, so the flag can be
  // settled on the same edge that writes the last slice.
  logic nz_q, nz_d;
  logic zero_q, zero_d;

  always_comb begin
    nz_d   = nz_q;
    zero_d = zero_q;
    if (state_q == ST_IDLE && start) begin
      nz_d   = 1'b0;
      zero_d = 1'b0;
    end else if (state_q == ST_RUN) begin
      nz_d = nz_q | (|slice_y);
      if (cnt_q == CNT_LAST) begin
        zero_d = ~(nz_q | (|slice_y));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nz_q   <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      nz_q   <= nz_d;
      zero_q <= zero_d;
    end
  end

  assign Zero = zero_q;
`endif

endmodule

// File: tb/tb_logic16_serial.sv
// Self-checking bench for logic16_serial: directed cases, busy-ignore,
// reset abort, start held high, and randomized transactions against a
// whole-word reference model.
module tb_logic16_serial;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] A, B;
  logic [1:0]  Op;
  logic [15:0] Out;
  logic        done, busy;
`ifdef LOGIC16_ZERO_FLAG_EN
  logic        Zero;
`endif

  int n_total = 0;
  int n_bad   = 0;

  logic16_serial #(.WIDTH(16), .SLICE(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .Op    (Op),
    .Out   (Out),
    .done  (done),
`ifdef LOGIC16_ZERO_FLAG_EN
    .Zero  (Zero),
`endif
    .busy  (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_op(input logic [15:0] a, input logic [15:0] b,
                                         input logic [1:0] op);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return a & ~b;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One transaction from an idle DUT. Operands are scrambled right after
  // acceptance; with inject, a start with all-ones operands is pulsed mid-run.
  task automatic do_txn(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                        input bit inject, input string tag);
    logic [15:0] expv;
    int          edges, busy_cnt, done_cnt;
    bit          seen;
    expv = ref_op(a, b, op);
    @(negedge clk);
    A = a; B = b; Op = op; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = 16'($urandom); B = 16'($urandom); Op = 2'($urandom);
`ifdef LOGIC16_ZERO_FLAG_EN
    chk({tag, "_zero_clr"}, Zero, 1'b0);
`endif
    edges = 1; busy_cnt = 0; done_cnt = 0; seen = 0;
    while (!seen && edges < 20) begin
      if (busy) busy_cnt++;
      if (done) begin
        seen = 1;
        done_cnt++;
      end else begin
        if (inject && edges == 2) begin
          A = 16'hFFFF; B = 16'hFFFF; Op = 2'b01; start = 1'b1;
        end
        @(posedge clk); #1;
        start = 1'b0;
        edges++;
      end
    end
    chk({tag, "_latency"}, edges, 5);
    chk({tag, "_busy_cycles"}, busy_cnt, 5);
    chk({tag, "_out"}, Out, expv);
`ifdef LOGIC16_ZERO_FLAG_EN
    chk({tag, "_zero"}, Zero, (expv == 16'h0));
`endif
    @(posedge clk); #1;
    if (done) done_cnt++;
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_idle_busy"}, busy, 1'b0);
    chk({tag, "_out_hold"}, Out, expv);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Op = '0;
    #12;
    chk("rst_out", Out, 16'h0);
    chk("rst_done", done, 1'b0);
    chk("rst_busy", busy, 1'b0);
`ifdef LOGIC16_ZERO_FLAG_EN
    chk("rst_zero", Zero, 1'b0);
`endif
    @(negedge clk); rst_n = 1'b1;

    // AND with a start pulse injected while running
    do_txn(16'hF0F0, 16'hFF00, 2'b00, 1'b1, "and");
    do_txn(16'h1234, 16'h00FF, 2'b01, 1'b0, "or");
    do_txn(16'h1234, 16'h00FF, 2'b10, 1'b0, "xor");
    do_txn(16'h1234, 16'h00FF, 2'b11, 1'b0, "andn");
    do_txn(16'hAAAA, 16'h5555, 2'b00, 1'b0, "zero_and");
    do_txn(16'hAAAA, 16'h5555, 2'b01, 1'b0, "zero_or");

    // reset in the middle of a run
    begin : rst_mid
      bit seen;
      @(negedge clk);
      A = 16'hFFFF; B = 16'h0000; Op = 2'b01; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rstmid_out", Out, 16'h0);
      chk("rstmid_done", done, 1'b0);
      chk("rstmid_busy", busy, 1'b0);
      @(negedge clk); rst_n = 1'b1;
      seen = 0;
      repeat (8) begin
        @(posedge clk); #1;
        if (done) seen = 1;
      end
      chk("rstmid_no_done", seen, 1'b0);
      chk("rstmid_out_after", Out, 16'h0);
    end

    // start held high: accepted only when idle, one idle cycle between runs
    begin : b2b
      logic [15:0] expq[$];
      logic [15:0] exp_now;
      logic        pre_busy;
      int          cyc, last_done, ndone;
      cyc = 0; last_done = -1; ndone = 0;
      @(negedge clk);
      start = 1'b1;
      while (ndone < 4 && cyc < 100) begin
        A = 16'($urandom); B = 16'($urandom); Op = 2'($urandom);
        pre_busy = busy;
        exp_now  = ref_op(A, B, Op);
        @(posedge clk); #1;
        cyc++;
        if (!pre_busy) expq.push_back(exp_now);
        if (done) begin
          if (expq.size() == 0) chk("b2b_queue", 0, 1);
          else chk("b2b_out", Out, expq.pop_front());
          if (last_done >= 0) chk("b2b_gap", cyc - last_done, 6);
          last_done = cyc;
          ndone++;
        end
        @(negedge clk);
      end
      start = 1'b0;
      chk("b2b_count", ndone, 4);
      chk("b2b_pending", expq.size(), 0);
      repeat (2) @(posedge clk);
      #1;
      chk("b2b_idle", busy, 1'b0);
    end

    for (int i = 0; i < 24; i++) begin
      do_txn(16'($urandom), 16'($urandom), 2'($urandom), 1'($urandom), "rand");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
